cache_ctrl_nway: RTL and testbench

//  Control FSM for a WAYS-way set-associative cache between the system port and external RAM.
//  Per-set tag, valid, dirty and age arrays sit outside this block; it sees only the addressed set's vectors.

---
 rtl/cache_pkg.sv | 34 +++
 rtl/cache_victim_sel.sv | 41 ++++
 rtl/cache_ctrl_nway.sv | 189 ++++++++++++++++++
 tb/tb_cache_ctrl_nway.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the n-way cache controller.
package cache_pkg;

    localparam int TMO_W     = 8;
    localparam int POLICY_WB = 0;
    localparam int POLICY_WT = 1;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE    = 4'd0;
    localparam state_t S_LOOKUP  = 4'd1;
    localparam state_t S_EVICT   = 4'd2;
    localparam state_t S_FILL    = 4'd3;
    localparam state_t S_INSTALL = 4'd4;
    localparam state_t S_ACCESS  = 4'd5;
    localparam state_t S_WT      = 4'd6;
    localparam state_t S_RESP    = 4'd7;
    localparam state_t S_ERR     = 4'd8;

    typedef struct packed {
        logic sys_ack;
        logic sys_err;
        logic tag_wr;
        logic data_wr;
        logic data_sel;
        logic dirty_set;
        logic dirty_clr;
        logic age_touch;
        logic addr_sel;
        logic ram_req;
        logic ram_we;
    } ctrl_out_t;

endpackage

// File: rtl/cache_victim_sel.sv
// Combinational hit decode and replacement-victim choice for the addressed set.
module cache_victim_sel
    import cache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] hit_idx,
    output logic             multi_hit,
    output logic [WAY_W-1:0] victim_idx,
    output logic             victim_valid
);

    logic seen;

    // Descending scan for invalid ways so the lowest-index one wins.
    always_comb begin
        hit_idx      = '0;
        multi_hit    = 1'b0;
        seen         = 1'b0;
        victim_idx   = lru_way;
        victim_valid = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_vec[i]) begin
                multi_hit = multi_hit | seen;
                seen      = 1'b1;
                hit_idx   = WAY_W'(i);
            end
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                victim_idx   = WAY_W'(i);
                victim_valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_nway.sv
// Control FSM for a WAYS-way set-associative cache: lookup, evict, fill, access,
// optional write-through, with RAM timeout and multi-hit error reporting.
module cache_ctrl_nway
    import cache_pkg::*;
#(
    parameter int WAYS    = 4,
    parameter int WAY_W   = 2,
    parameter int POLICY  = 0,
    parameter int RAM_TMO = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sys_rd,
    input  logic             sys_wr,
    output logic             sys_ack,
    output logic             sys_err,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic [WAYS-1:0]  valid_vec,
    input  logic [WAYS-1:0]  dirty_vec,
    input  logic [WAY_W-1:0] lru_way,
    output logic [WAY_W-1:0] way_sel,
    output logic             tag_wr,
    output logic             data_wr,
    output logic             data_sel,
    output logic             dirty_set,
    output logic             dirty_clr,
    output logic             age_touch,
    output logic             addr_sel,
    output logic             ram_req,
    output logic             ram_we,
    input  logic             ram_ack
);

    state_t             state_q, state_d;
    logic               pend_rd_q, pend_rd_d;
    logic               pend_wr_q, pend_wr_d;
    logic [WAY_W-1:0]   way_q, way_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    ctrl_out_t          out_q, out_d;

    logic [WAY_W-1:0]   hit_idx;
    logic [WAY_W-1:0]   victim_idx;
    logic               multi_hit;
    logic               victim_valid;
    logic               ack_ok;
    logic               tmo_hit;

    cache_victim_sel #(
        .WAYS  (WAYS),
        .WAY_W (WAY_W)
    ) u_victim_sel (
        .valid_vec    (valid_vec),
        .hit_vec      (hit_vec),
        .lru_way      (lru_way),
        .hit_idx      (hit_idx),
        .multi_hit    (multi_hit),
        .victim_idx   (victim_idx),
        .victim_valid (victim_valid)
    );

    // Outputs are computed from the current state and registered, so they trail the state by a cycle.
    always_comb begin
        state_d   = state_q;
        pend_rd_d = pend_rd_q;
        pend_wr_d = pend_wr_q;
        way_d     = way_q;
        tmo_d     = '0;
        out_d     = '0;
        ack_ok    = out_q.ram_req && ram_ack;
        tmo_hit   = (RAM_TMO != 0) && out_q.ram_req && !ram_ack &&
                    (tmo_q == TMO_W'(RAM_TMO - 1));

        if (out_q.sys_ack) begin
            pend_rd_d = 1'b0;
            pend_wr_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                // The ack cycle still sees the finished request held high, so skip it.
                if (!out_q.sys_ack && (sys_rd || sys_wr)) begin
                    pend_wr_d = sys_wr;
                    pend_rd_d = !sys_wr;
                    state_d   = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (!pend_rd_q && !pend_wr_q) begin
                    state_d = S_IDLE;
                end else if (multi_hit) begin
                    state_d = S_ERR;
                end else if (|hit_vec) begin
                    way_d   = hit_idx;
                    state_d = S_ACCESS;
                end else begin
                    way_d = victim_idx;
                    if (POLICY == POLICY_WB && victim_valid && dirty_vec[victim_idx]) begin
                        state_d = S_EVICT;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_EVICT, S_FILL, S_WT: begin
                out_d.ram_req  = 1'b1;
                out_d.ram_we   = (state_q != S_FILL);
                out_d.addr_sel = (state_q == S_EVICT);
                if (out_q.ram_req) begin
                    tmo_d = tmo_q + 1'b1;
                end
                if (ack_ok) begin
                    out_d           = '0;
                    out_d.dirty_clr = (state_q == S_EVICT);
                    tmo_d           = '0;
                    case (state_q)
                        S_EVICT: state_d = S_FILL;
                        S_FILL:  state_d = S_INSTALL;
                        default: state_d = S_RESP;
                    endcase
                end else if (tmo_hit) begin
                    out_d   = '0;
                    state_d = S_ERR;
                end
            end
            S_INSTALL: begin
                out_d.tag_wr   = 1'b1;
                out_d.data_wr  = 1'b1;
                out_d.data_sel = 1'b1;
                state_d        = S_ACCESS;
            end
            S_ACCESS: begin
                out_d.age_touch = 1'b1;
                state_d         = S_RESP;
                if (pend_wr_q) begin
                    out_d.data_wr = 1'b1;
                    if (POLICY == POLICY_WB) begin
                        out_d.dirty_set = 1'b1;
                    end else begin
                        state_d = S_WT;
                    end
                end
            end
            S_RESP: begin
                out_d.sys_ack = 1'b1;
                state_d       = S_IDLE;
            end
            S_ERR: begin
                out_d.sys_ack = 1'b1;
                out_d.sys_err = 1'b1;
                state_d       = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            pend_rd_q <= 1'b0;
            pend_wr_q <= 1'b0;
            way_q     <= '0;
            tmo_q     <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            pend_rd_q <= pend_rd_d;
            pend_wr_q <= pend_wr_d;
            way_q     <= way_d;
            tmo_q     <= tmo_d;
            out_q     <= out_d;
        end
    end

    assign way_sel   = way_q;
    assign sys_ack   = out_q.sys_ack;
    assign sys_err   = out_q.sys_err;
    assign tag_wr    = out_q.tag_wr;
    assign data_wr   = out_q.data_wr;
    assign data_sel  = out_q.data_sel;
    assign dirty_set = out_q.dirty_set;
    assign dirty_clr = out_q.dirty_clr;
    assign age_touch = out_q.age_touch;
    assign addr_sel  = out_q.addr_sel;
    assign ram_req   = out_q.ram_req;
    assign ram_we    = out_q.ram_we;

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Scoreboard bench for cache_ctrl_nway: a write-back and a write-through instance,
// directed transactions with hand-computed latency and per-transaction pulse counts.
module tb_cache_ctrl_nway;

    typedef struct {
        int lat;
        int err;
        int way;
        int n_tag;
        int n_data;
        int n_dset;
        int n_dclr;
        int n_age;
        int n_req;
        int n_we;
        int n_vic;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sel = 1'b0;
    logic [1:0] sys_rd_v = '0;
    logic [1:0] sys_wr_v = '0;
    logic       ack_drv = 1'b0;
    logic [3:0] hit_vec = '0;
    logic [3:0] valid_vec = '0;
    logic [3:0] dirty_vec = '0;
    logic [1:0] lru_way = '0;

    wire [1:0] sys_ack_v, sys_err_v, tag_wr_v, data_wr_v, data_sel_v, dirty_set_v;
    wire [1:0] dirty_clr_v, age_touch_v, addr_sel_v, ram_req_v, ram_we_v;
    wire [1:0] way0, way1;
    wire [1:0] ram_ack_v = sel ? {ack_drv, 1'b0} : {1'b0, ack_drv};

    wire       m_ack  = sys_ack_v[sel];
    wire       m_err  = sys_err_v[sel];
    wire       m_tag  = tag_wr_v[sel];
    wire       m_data = data_wr_v[sel];
    wire       m_dset = dirty_set_v[sel];
    wire       m_dclr = dirty_clr_v[sel];
    wire       m_age  = age_touch_v[sel];
    wire       m_addr = addr_sel_v[sel];
    wire       m_req  = ram_req_v[sel];
    wire       m_we   = ram_we_v[sel];
    wire [1:0] m_way  = sel ? way1 : way0;
    wire [25:0] all_outs = {sys_ack_v, sys_err_v, tag_wr_v, data_wr_v, data_sel_v, dirty_set_v,
                            dirty_clr_v, age_touch_v, addr_sel_v, ram_req_v, ram_we_v, way0, way1};

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   ram_dly = 0;
    int   ram_cnt = 0;
    int   n_tag = 0, n_data = 0, n_dset = 0, n_dclr = 0, n_age = 0;
    int   n_req = 0, n_we = 0, n_vic = 0;
    exp_t exp_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    cache_ctrl_nway #(.WAYS(4), .WAY_W(2), .POLICY(0), .RAM_TMO(16)) dut_wb (
        .clk(clk), .reset(reset), .sys_rd(sys_rd_v[0]), .sys_wr(sys_wr_v[0]),
        .sys_ack(sys_ack_v[0]), .sys_err(sys_err_v[0]), .hit_vec(hit_vec),
        .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way), .way_sel(way0),
        .tag_wr(tag_wr_v[0]), .data_wr(data_wr_v[0]), .data_sel(data_sel_v[0]),
        .dirty_set(dirty_set_v[0]), .dirty_clr(dirty_clr_v[0]), .age_touch(age_touch_v[0]),
        .addr_sel(addr_sel_v[0]), .ram_req(ram_req_v[0]), .ram_we(ram_we_v[0]),
        .ram_ack(ram_ack_v[0]));

    cache_ctrl_nway #(.WAYS(4), .WAY_W(2), .POLICY(1), .RAM_TMO(16)) dut_wt (
        .clk(clk), .reset(reset), .sys_rd(sys_rd_v[1]), .sys_wr(sys_wr_v[1]),
        .sys_ack(sys_ack_v[1]), .sys_err(sys_err_v[1]), .hit_vec(hit_vec),
        .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way), .way_sel(way1),
        .tag_wr(tag_wr_v[1]), .data_wr(data_wr_v[1]), .data_sel(data_sel_v[1]),
        .dirty_set(dirty_set_v[1]), .dirty_clr(dirty_clr_v[1]), .age_touch(age_touch_v[1]),
        .addr_sel(addr_sel_v[1]), .ram_req(ram_req_v[1]), .ram_we(ram_we_v[1]),
        .ram_ack(ram_ack_v[1]));

    task automatic checkOutput(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, act, req);
        end
    endtask

    function automatic exp_t mkExp(input int lat, input int err, input int way, input int tag,
                                   input int data, input int dset, input int dclr, input int age,
                                   input int req, input int we, input int vic);
        exp_t e;
        e.lat = lat; e.err = err; e.way = way; e.n_tag = tag; e.n_data = data;
        e.n_dset = dset; e.n_dclr = dclr; e.n_age = age; e.n_req = req; e.n_we = we; e.n_vic = vic;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: acks on the ram_dly-th cycle of a held request; ram_dly = 0 never acks.
    always @(negedge clk) begin
        if (reset) begin
            ack_drv = 1'b0;
            ram_cnt = 0;
        end else if (ack_drv) begin
            ack_drv = 1'b0;
            ram_cnt = 0;
        end else if (m_req) begin
            ram_cnt++;
            if (ram_dly != 0 && ram_cnt == ram_dly) ack_drv = 1'b1;
        end
    end

    // Monitor: accumulate pulse counts, compare against the scoreboard on every sys_ack.
    always @(negedge clk) begin
        if (reset) begin
            n_tag = 0; n_data = 0; n_dset = 0; n_dclr = 0; n_age = 0; n_req = 0; n_we = 0; n_vic = 0;
        end else begin
            n_tag  += int'(m_tag);
            n_data += int'(m_data);
            n_dset += int'(m_dset);
            n_dclr += int'(m_dclr);
            n_age  += int'(m_age);
            n_req  += int'(m_req);
            n_we   += int'(m_req & m_we);
            n_vic  += int'(m_req & m_addr);
            if (m_ack) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_ack: got ack, wanted none");
                end else begin
                    cur = exp_q.pop_front();
                    checkOutput("latency", cyc - start_cyc - 1, cur.lat);
                    checkOutput("sys_err", int'(m_err), cur.err);
                    if (cur.way >= 0) checkOutput("way_sel", int'(m_way), cur.way);
                    checkOutput("tag_wr_cnt", n_tag, cur.n_tag);
                    checkOutput("data_wr_cnt", n_data, cur.n_data);
                    checkOutput("dirty_set_cnt", n_dset, cur.n_dset);
                    checkOutput("dirty_clr_cnt", n_dclr, cur.n_dclr);
                    checkOutput("age_touch_cnt", n_age, cur.n_age);
                    checkOutput("ram_req_cycles", n_req, cur.n_req);
                    checkOutput("ram_we_cycles", n_we, cur.n_we);
                    checkOutput("victim_addr_cycles", n_vic, cur.n_vic);
                end
                n_tag = 0; n_data = 0; n_dset = 0; n_dclr = 0; n_age = 0; n_req = 0; n_we = 0; n_vic = 0;
            end
        end
    end

    task automatic applyStimulus(input bit d, input bit rd, input bit wr, input logic [3:0] hv,
                                 input logic [3:0] vv, input logic [3:0] dv, input logic [1:0] lru,
                                 input int dly, input exp_t e);
        int waited;
        @(negedge clk);
        sel       = d;
        hit_vec   = hv;
        valid_vec = vv;
        dirty_vec = dv;
        lru_way   = lru;
        ram_dly   = dly;
        exp_q.push_back(e);
        start_cyc = cyc;
        sys_rd_v[d] = rd;
        sys_wr_v[d] = wr;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!m_ack && waited < 100);
        if (!m_ack) begin
            total++;
            bad++;
            $display("[TB] FAIL ack_timeout: no sys_ack after %0d cycles, wanted one", waited);
            exp_q.delete();
        end
        sys_rd_v = '0;
        sys_wr_v = '0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        checkOutput("outs_during_reset", int'(all_outs), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("outs_after_reset", int'(all_outs), 0);

        $display("[TB] read hit way 1");
        applyStimulus(0, 1, 0, 4'b0010, 4'b1111, 4'b0000, 2'd0, 1, mkExp(3, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        $display("[TB] write hit way 0, write-back");
        applyStimulus(0, 0, 1, 4'b0001, 4'b1111, 4'b0000, 2'd3, 1, mkExp(3, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        $display("[TB] dirty write miss, evict way 2");
        applyStimulus(0, 0, 1, 4'b0000, 4'b1111, 4'b0100, 2'd2, 4, mkExp(14, 0, 2, 1, 2, 1, 1, 1, 8, 4, 4));
        $display("[TB] read miss, invalid way 2 beats lru 0");
        applyStimulus(0, 1, 0, 4'b0000, 4'b1011, 4'b1111, 2'd0, 2, mkExp(7, 0, 2, 1, 1, 0, 0, 1, 2, 0, 0));
        $display("[TB] clean read miss on lru way 1");
        applyStimulus(0, 1, 0, 4'b0000, 4'b1111, 4'b1101, 2'd1, 1, mkExp(6, 0, 1, 1, 1, 0, 0, 1, 1, 0, 0));
        $display("[TB] read and write together, write wins");
        applyStimulus(0, 1, 1, 4'b0001, 4'b1111, 4'b0000, 2'd2, 1, mkExp(3, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
        $display("[TB] write-through write hit way 3");
        applyStimulus(1, 0, 1, 4'b1000, 4'b1111, 4'b0000, 2'd0, 3, mkExp(7, 0, 3, 0, 1, 0, 0, 1, 3, 3, 0));
        $display("[TB] write-through write miss, dirty victim not evicted");
        applyStimulus(1, 0, 1, 4'b0000, 4'b1111, 4'b1111, 2'd1, 2, mkExp(10, 0, 1, 1, 2, 0, 0, 1, 4, 2, 0));
        $display("[TB] fill timeout");
        applyStimulus(0, 1, 0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 0, mkExp(19, 1, 3, 0, 0, 0, 0, 0, 16, 0, 0));
        $display("[TB] multi-hit");
        applyStimulus(0, 1, 0, 4'b0110, 4'b1111, 4'b0000, 2'd0, 1, mkExp(2, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("[TB] reset during fill");
        @(negedge clk);
        sel = 1'b0; hit_vec = 4'b0000; valid_vec = 4'b1111; dirty_vec = 4'b0000; lru_way = 2'd0;
        ram_dly = 0;
        sys_rd_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("req_before_reset", int'(ram_req_v[0]), 1);
        reset = 1'b1;
        #1;
        checkOutput("req_in_reset", int'(ram_req_v[0]), 0);
        checkOutput("outs_in_reset", int'(all_outs), 0);
        sys_rd_v = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        applyStimulus(0, 1, 0, 4'b0100, 4'b1111, 4'b0000, 2'd0, 1, mkExp(3, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0));

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
